lead_one_enc32: RTL and testbench
=================================

LEAD_ONE_ENC32 -- requirements
Module: lead_one_enc32

Interface
REQ-001 Parameter: T, 0.000, unit gate delay for simulation only; all combinational assigns carry delay in multiples of T; T SHALL NOT affect function.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset: synchronous and active-high.
REQ-004 in_valid  input  1  in_data holds a word to encode.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  32  word whose most-significant set bit is located.
REQ-007 out_valid  output  1  out_idx/out_zero hold a finished result.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 out_idx  output  5  bit position of the most-significant 1 in the accepted word (0..31).
REQ-010 out_zero  output  1  accepted word was all zeros.

Function
REQ-011 The block SHALL be the inverse of a 32:1 bit select: given the word, it returns the 5-bit index of its leading 1, bit 4 resolved first, bit 0 last.
REQ-012 FSM states SHALL be IDLE, SEARCH and DONE, one state register, encoding free.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a clock edge, capture in_data into d, clear idx to 0, load step k=4, set zero flag = (in_data==0), go to SEARCH.
REQ-014 IDLE with in_valid=0 SHALL hold state and registers.
REQ-015 SEARCH: in_ready=0, out_valid=0; each edge: c = idx | (1<<k); if (d >> c) != 0 then idx[k] <= 1, else idx[k] stays 0; k decrements.
REQ-016 SEARCH SHALL take exactly 5 edges (k=4,3,2,1,0); the edge with k=0 transitions to DONE.
REQ-017 in_data and in_valid SHALL be ignored outside IDLE; d is not reloaded mid-search.
REQ-018 DONE: out_valid=1, in_ready=0, out_idx=idx, out_zero=zero flag; outputs SHALL be stable while out_ready=0.
REQ-019 DONE with out_ready=1 at an edge SHALL return to IDLE; no new word is accepted on that same edge.
REQ-020 Latency: accept edge E0, result visible after edge E5 (out_valid high in the cycle after E5); minimum spacing between accepts is 7 cycles.
REQ-021 Zero word: search runs the full 5 steps, yielding out_idx=0 with out_zero=1; out_zero=0 for every nonzero word.
REQ-022 Word 0x00000001 SHALL give out_idx=0, out_zero=0, distinguishable from zero input only by out_zero.
REQ-023 out_idx and out_zero SHALL be driven directly from registers (no combinational path from in_data or out_ready).
REQ-024 in_ready and out_valid SHALL be pure functions of the state register.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, d=0, idx=0, k=4, zero flag=0, irrespective of state or handshake inputs.
REQ-026 After reset: in_ready=1, out_valid=0, out_idx=0, out_zero=0.
REQ-027 rst asserted during SEARCH or DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-028 rst has priority over an accept or an out_ready handshake on the same edge.

Verification
REQ-029 Accept 0x80000000 -> out_valid after E5, out_idx=31, out_zero=0.
REQ-030 Accept 0x00010F00 -> out_idx=16; then 0x00000001 -> out_idx=0, out_zero=0; then 0x00000000 -> out_idx=0, out_zero=1.
REQ-031 Hold out_ready=0 for 10 cycles in DONE with result 0x0000_4000 (out_idx=14) -> out_valid, out_idx stay constant; in_ready=0; new in_valid ignored.
REQ-032 Change in_data every cycle during SEARCH after accepting 0x00000300 -> result still out_idx=9.
REQ-033 Assert rst on the 3rd SEARCH edge after accepting 0xFFFFFFFF -> next cycle in_ready=1, out_valid=0, out_idx=0; no result ever presented.
REQ-034 Exhaustive sweep: for n=0..31 accept (1<<n) | random lower bits -> out_idx=n; back-to-back traffic with out_ready=1 gives one result per 7 cycles.

Source files
------------

// File: rtl/lead_one_enc32.sv
// Leading-one encoder for a 32-bit word, resolved one index bit per clock (bit 4 first).
// Handshaked input and output; the result stays registered until the consumer takes it.
module lead_one_enc32 #(
  parameter real T = 0.0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic        out_zero
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] d_reg, d_next;
  logic [4:0]  idx_reg, idx_next;
  logic [2:0]  k_reg, k_next;
  logic        zero_reg, zero_next;

  logic [4:0]  probe;
  logic [31:0] probe_mask;
  logic        probe_hit;

  // T scales simulation-only gate delay and never changes behaviour; nothing to build.
  if (T < 0.0) begin : g_t_unused
  end

  // Trial index: already-resolved upper bits plus the bit under test.
  assign probe = idx_reg | (5'd1 << k_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mask
      assign probe_mask[gi] = (5'(gi) >= probe);
    end
  endgenerate

  // Any set bit at or above the trial index means (d >> probe) != 0.
  assign probe_hit = |(d_reg & probe_mask);

  always_comb begin
    state_next = state_reg;
    d_next     = d_reg;
    idx_next   = idx_reg;
    k_next     = k_reg;
    zero_next  = zero_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          d_next     = in_data;
          idx_next   = 5'd0;
          k_next     = 3'd4;
          zero_next  = (in_data == 32'd0);
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (probe_hit) idx_next[k_reg] = 1'b1;
        if (k_reg == 3'd0) begin
          state_next = DONE;
        end else begin
          k_next = k_reg - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      d_reg     <= 32'd0;
      idx_reg   <= 5'd0;
      k_reg     <= 3'd4;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      d_reg     <= d_next;
      idx_reg   <= idx_next;
      k_reg     <= k_next;
      zero_reg  <= zero_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_idx   = idx_reg;
  assign out_zero  = zero_reg;

endmodule

// File: tb/tb_lead_one_enc32.sv
// Randomized self-checking bench for lead_one_enc32 against a plain leading-one model.
module tb_lead_one_enc32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_zero;

  int checks = 0;
  int failures = 0;

  lead_one_enc32 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Model: highest set bit by scanning the word; zero flag for an empty word.
  function automatic logic [5:0] ref_enc(input logic [31:0] w);
    logic [4:0] i = 5'd0;
    for (int n = 0; n < 32; n++) if (w[n]) i = 5'(n);
    return {(w == 32'd0), i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, wait for the result, optionally stall the consumer, then release.
  task automatic run_word(input logic [31:0] w, input int hold, input bit scramble);
    logic [5:0] exp;
    int cyc;
    logic [4:0] held_idx;
    exp = ref_enc(w);
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ready_in_search", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (scramble) begin
        in_data  = $urandom;
        in_valid = 1'($urandom);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'd5);
    check("out_idx", 32'(out_idx), 32'(exp[4:0]));
    check("out_zero", 32'(out_zero), 32'(exp[5]));
    held_idx = out_idx;
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      for (int h = 0; h < hold; h++) begin
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_idx", 32'(out_idx), 32'(held_idx));
        check("hold_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_ready", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd0);
    $display("txn word=0x%08h idx=%0d zero=%0d", w, held_idx, exp[5]);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] words[8];
    logic [5:0]  expq[$];
    logic [5:0]  e;
    int sent, got, last_acc;
    bit seen_valid;

    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_idx", 32'(out_idx), 32'd0);
    check("reset_zero", 32'(out_zero), 32'd0);

    // Idle with nothing offered holds.
    tick();
    check("idle_hold", 32'(in_ready), 32'd1);

    // Reset wins over an accept on the same edge.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h8000_0000;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_over_accept", 32'(in_ready), 32'd1);

    run_word(32'h8000_0000, 0, 0);
    run_word(32'h0001_0F00, 0, 0);
    run_word(32'h0000_0001, 0, 0);
    run_word(32'h0000_0000, 0, 0);
    run_word(32'h0000_4000, 10, 0);
    run_word(32'h0000_0300, 0, 1);

    // Abort on the 3rd search edge.
    in_data = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_idx", 32'(out_idx), 32'd0);
    seen_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin tick(); if (out_valid) seen_valid = 1'b1; end
    check("abort_no_result", 32'(seen_valid), 32'd0);

    // Sweep every leading-one position with random lower bits.
    for (int n = 0; n < 32; n++) begin
      w = (32'd1 << n) | ($urandom & ((32'd1 << n) - 32'd1));
      run_word(w, 0, 1);
    end

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 8; i++) words[i] = $urandom >> $urandom_range(0, 31);
    out_ready = 1'b1;
    sent = 0; got = 0; last_acc = 0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      if (out_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 6'h3F;
        check("stream_idx", 32'(out_idx), 32'(e[4:0]));
        check("stream_zero", 32'(out_zero), 32'(e[5]));
        $display("stream result %0d idx=%0d zero=%0d", got, out_idx, out_zero);
        got++;
      end
      if (in_ready && sent < 8) begin
        if (sent > 0) check("stream_spacing", 32'(c - last_acc), 32'd7);
        last_acc = c;
        in_data  = words[sent];
        in_valid = 1'b1;
        expq.push_back(ref_enc(words[sent]));
        sent++;
      end else if (sent >= 8) begin
        in_valid = 1'b0;
      end
      tick();
    end
    check("stream_count", 32'(got), 32'd8);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
